// File: rtl/png_chunk_wrap.sv
// png_chunk_wrap: wraps a payload stream into a PNG chunk.
// It emits the length word, the type word, the payload words and then the CRC word. It also
// drives an external CRC-32 engine over the type and payload bytes.
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   start_i, len_i,      chunk start request with the byte length and type, honoured in IDLE
//   type_i
//   val_i, dat_i, num_i, payload word in; num_i = valid MS bytes - 1; rdy_o accepts it
//   lst_i, rdy_o
//   crc_start_o, crc_val_o, crc_lst_o, crc_dat_o, crc_num_o   feed to the CRC-32 engine
//   crc_done_i, crc_dat_i                                      final CRC from the engine
//   val_o, lst_o, done_o, dat_o, num_o                         output word stream
//   err_o                sticky payload length error
//
// Optional feature: define PNG_CHUNK_LEN_CHK_EN to count payload bytes and flag a length
// mismatch on err_o. Without it err_o is tied low.
module png_chunk_wrap (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic [31:0] len_i,
    input  logic [31:0] type_i,
    input  logic        val_i,
    input  logic [31:0] dat_i,
    input  logic [1:0]  num_i,
    input  logic        lst_i,
    output logic        rdy_o,
    output logic        crc_start_o,
    output logic        crc_val_o,
    output logic        crc_lst_o,
    output logic [31:0] crc_dat_o,
    output logic [1:0]  crc_num_o,
    input  logic        crc_done_i,
    input  logic [31:0] crc_dat_i,
    output logic        val_o,
    output logic        lst_o,
    output logic        done_o,
    output logic [31:0] dat_o,
    output logic [1:0]  num_o,
    output logic        err_o
);

    typedef enum logic [1:0] {StIdle, StType, StData, StCrcWait} state_e;

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic [31:0] len_q;
    logic [31:0] type_q;
    logic        accept;

    // cnt spaces CRC engine words at least four cycles apart.
    assign rdy_o  = (state_q == StData) && (cnt_q == 2'd0);
    assign accept = val_i && rdy_o;

`ifdef PNG_CHUNK_LEN_CHK_EN
    logic [31:0] byte_cnt_q;
    logic [31:0] byte_cnt_nxt;
    logic        err_q;

    assign byte_cnt_nxt = byte_cnt_q + {30'd0, num_i} + 32'd1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_cnt_q <= 32'd0;
            err_q      <= 1'b0;
        end else if (state_q == StIdle && start_i) begin
            byte_cnt_q <= 32'd0;
            err_q      <= 1'b0;
        end else if (accept) begin
            byte_cnt_q <= byte_cnt_nxt;
            // Too many bytes so far, or the last word does not land exactly on len.
            if ((lst_i && byte_cnt_nxt != len_q) || byte_cnt_nxt > len_q) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= StIdle;
            cnt_q       <= 2'd0;
            len_q       <= 32'd0;
            type_q      <= 32'd0;
            val_o       <= 1'b0;
            lst_o       <= 1'b0;
            done_o      <= 1'b0;
            dat_o       <= 32'd0;
            num_o       <= 2'd0;
            crc_start_o <= 1'b0;
            crc_val_o   <= 1'b0;
            crc_lst_o   <= 1'b0;
            crc_dat_o   <= 32'd0;
            crc_num_o   <= 2'd0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            val_o       <= 1'b0;
            lst_o       <= 1'b0;
            done_o      <= 1'b0;
            crc_start_o <= 1'b0;
            crc_val_o   <= 1'b0;
            crc_lst_o   <= 1'b0;

            if (cnt_q != 2'd0) begin
                cnt_q <= cnt_q - 2'd1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        len_q       <= len_i;
                        type_q      <= type_i;
                        val_o       <= 1'b1;
                        dat_o       <= len_i;
                        num_o       <= 2'd3;
                        crc_start_o <= 1'b1;
                        state_q     <= StType;
                    end
                end
                StType: begin
                    val_o     <= 1'b1;
                    dat_o     <= type_q;
                    num_o     <= 2'd3;
                    crc_val_o <= 1'b1;
                    crc_dat_o <= type_q;
                    crc_num_o <= 2'd3;
                    crc_lst_o <= (len_q == 32'd0);
                    cnt_q     <= 2'd3;
                    state_q   <= (len_q == 32'd0) ? StCrcWait : StData;
                end
                StData: begin
                    if (accept) begin
                        val_o     <= 1'b1;
                        dat_o     <= dat_i;
                        num_o     <= num_i;
                        crc_val_o <= 1'b1;
                        crc_dat_o <= dat_i;
                        crc_num_o <= num_i;
                        crc_lst_o <= lst_i;
                        cnt_q     <= 2'd3;
                        if (lst_i) begin
                            state_q <= StCrcWait;
                        end
                    end
                end
                StCrcWait: begin
                    if (crc_done_i) begin
                        val_o   <= 1'b1;
                        dat_o   <= crc_dat_i;
                        num_o   <= 2'd3;
                        lst_o   <= 1'b1;
                        done_o  <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_png_chunk_wrap.sv
// Testbench for png_chunk_wrap. It contains a behavioural CRC-32 engine and a reference model
// that predicts each chunk's output words from the byte stream.
module tb_png_chunk_wrap;

`ifdef PNG_CHUNK_LEN_CHK_EN
    localparam bit LenChk = 1'b1;
`else
    localparam bit LenChk = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        start_i;
    logic [31:0] len_i;
    logic [31:0] type_i;
    logic        val_i;
    logic [31:0] dat_i;
    logic [1:0]  num_i;
    logic        lst_i;
    logic        rdy_o;
    logic        crc_start_o;
    logic        crc_val_o;
    logic        crc_lst_o;
    logic [31:0] crc_dat_o;
    logic [1:0]  crc_num_o;
    logic        crc_done;
    logic [31:0] eng_res;
    logic        val_o;
    logic        lst_o;
    logic        done_o;
    logic [31:0] dat_o;
    logic [1:0]  num_o;
    logic        err_o;

    int total = 0;
    int bad = 0;

    png_chunk_wrap dut (
        .clk        (clk),
        .rstn       (rstn),
        .start_i    (start_i),
        .len_i      (len_i),
        .type_i     (type_i),
        .val_i      (val_i),
        .dat_i      (dat_i),
        .num_i      (num_i),
        .lst_i      (lst_i),
        .rdy_o      (rdy_o),
        .crc_start_o(crc_start_o),
        .crc_val_o  (crc_val_o),
        .crc_lst_o  (crc_lst_o),
        .crc_dat_o  (crc_dat_o),
        .crc_num_o  (crc_num_o),
        .crc_done_i (crc_done),
        .crc_dat_i  (eng_res),
        .val_o      (val_o),
        .lst_o      (lst_o),
        .done_o     (done_o),
        .dat_o      (dat_o),
        .num_o      (num_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reflected CRC-32 (poly 0xEDB88320), one byte at a time.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [31:0] crc_word(input logic [31:0] c, input logic [31:0] w,
                                             input logic [1:0] n);
        logic [31:0] r;
        r = c;
        for (int i = 0; i <= int'(n); i++) r = crc_byte(r, w[31-8*i -: 8]);
        return r;
    endfunction

    // Behavioural CRC-32 engine: final CRC appears a few cycles after the last word.
    logic [31:0] eng_crc;
    logic [1:0]  eng_dly;
    always @(posedge clk) begin
        if (!rstn) begin
            eng_crc  <= '1;
            eng_dly  <= 2'd0;
            crc_done <= 1'b0;
            eng_res  <= 32'd0;
        end else begin
            crc_done <= 1'b0;
            if (crc_start_o) eng_crc <= '1;
            else if (crc_val_o) begin
                eng_crc <= crc_word(eng_crc, crc_dat_o, crc_num_o);
                if (crc_lst_o) eng_dly <= 2'd3;
            end
            if (eng_dly != 2'd0) begin
                eng_dly <= eng_dly - 2'd1;
                if (eng_dly == 2'd1) begin
                    crc_done <= 1'b1;
                    eng_res  <= ~eng_crc;
                end
            end
        end
    end

    // Monitor: samples outputs on the falling edge.
    typedef struct packed {
        logic [31:0] dat;
        logic [1:0]  num;
        logic        lst;
        logic        done;
        logic        st;
    } ow_t;

    ow_t mon_q[$];
    int  acc_cyc[$];
    int  cv_cyc[$];
    int  cyc = 0;
    int  rdy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (val_o) mon_q.push_back('{dat_o, num_o, lst_o, done_o, crc_start_o});
        if (crc_val_o) cv_cyc.push_back(cyc);
        if (val_i && rdy_o) acc_cyc.push_back(cyc);
        if (rdy_o) rdy_cnt <= rdy_cnt + 1;
    end

    logic [7:0] fixed_pay[$];

    // Run one chunk. len is the header value and plen is the number of payload bytes sent.
    task automatic run_chunk(input string nm, input logic [31:0] len, input int plen,
                             input logic [31:0] typ, input bit hold, input bit inject);
        ow_t        exp_q[$];
        logic [7:0] pay[$];
        logic [7:0] cb[$];
        logic [31:0] w;
        logic [31:0] c;
        int idx, n, k, r0, nwords;
        bit ok, sp_ok, exp_err;
        if (fixed_pay.size() > 0) pay = fixed_pay;
        else for (int i = 0; i < plen; i++) pay.push_back(8'($urandom));
        mon_q.delete();
        acc_cyc.delete();
        cv_cyc.delete();
        r0 = rdy_cnt;
        exp_q.push_back('{len, 2'd3, 1'b0, 1'b0, 1'b1});
        exp_q.push_back('{typ, 2'd3, 1'b0, 1'b0, 1'b0});

        @(posedge clk); #1;
        start_i = 1'b1; len_i = len; type_i = typ;
        @(posedge clk); #1;
        start_i = 1'b0; len_i = $urandom; type_i = $urandom;
        total++;
        if (err_o !== 1'b0) begin
            bad++;
            $display("FAIL %s err_clear_on_start: got %b want 0", nm, err_o);
        end
        if (inject) begin
            val_i = 1'b1; dat_i = $urandom; num_i = 2'($urandom); lst_i = 1'b1;
        end
        @(posedge clk); #1;
        val_i = 1'b0; lst_i = 1'b0;

        idx = 0;
        nwords = 0;
        while (idx < plen) begin
            n = (plen - idx > 4) ? 4 : plen - idx;
            w = (fixed_pay.size() > 0) ? 32'd0 : $urandom;
            for (int b = 0; b < n; b++) w[31-8*b -: 8] = pay[idx+b];
            if (!hold) repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            if (inject && idx == 0) begin
                start_i = 1'b1; len_i = 32'd7; type_i = $urandom;
                @(posedge clk); #1;
                start_i = 1'b0;
            end
            val_i = 1'b1; dat_i = w; num_i = 2'(n - 1); lst_i = (idx + n >= plen);
            k = 0;
            ok = 1'b0;
            while (!ok && k < 40) begin
                @(negedge clk);
                ok = rdy_o;
                k++;
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s accept_timeout: got no rdy_o want accept of word %0d", nm, nwords);
                val_i = 1'b0; lst_i = 1'b0;
                break;
            end
            exp_q.push_back('{w, 2'(n - 1), 1'b0, 1'b0, 1'b0});
            nwords++;
            @(posedge clk); #1;
            val_i = 1'b0; lst_i = 1'b0;
            idx += n;
        end

        k = 0;
        while (k < 60 && !(mon_q.size() > 0 && mon_q[mon_q.size()-1].done)) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k >= 60) begin
            bad++;
            $display("FAIL %s done_timeout: got no done_o want done within 60 cycles", nm);
        end

        for (int i = 0; i < 4; i++) cb.push_back(typ[31-8*i -: 8]);
        foreach (pay[i]) cb.push_back(pay[i]);
        c = '1;
        foreach (cb[i]) c = crc_byte(c, cb[i]);
        exp_q.push_back('{~c, 2'd3, 1'b1, 1'b1, 1'b0});

        total++;
        if (mon_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s word_count: got %0d want %0d", nm, mon_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            total++;
            if (mon_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s word%0d {dat,num,lst,done,start}: got %h want %h",
                         nm, i, mon_q[i], exp_q[i]);
            end
        end

        total++;
        if (cv_cyc.size() != nwords + 1) begin
            bad++;
            $display("FAIL %s crc_val_count: got %0d want %0d", nm, cv_cyc.size(), nwords + 1);
        end
        sp_ok = 1'b1;
        for (int i = 1; i < cv_cyc.size(); i++) begin
            if (hold ? (cv_cyc[i] - cv_cyc[i-1] != 4) : (cv_cyc[i] - cv_cyc[i-1] < 4)) sp_ok = 1'b0;
        end
        total++;
        if (!sp_ok) begin
            bad++;
            $display("FAIL %s crc_val_spacing: got irregular pulses want %s4 cycles apart",
                     nm, hold ? "" : ">=");
        end
        if (hold) begin
            sp_ok = 1'b1;
            for (int i = 1; i < acc_cyc.size(); i++)
                if (acc_cyc[i] - acc_cyc[i-1] != 4) sp_ok = 1'b0;
            total++;
            if (!sp_ok) begin
                bad++;
                $display("FAIL %s accept_spacing: got irregular accepts want 4 cycles apart", nm);
            end
        end
        if (len == 32'd0) begin
            total++;
            if (rdy_cnt != r0) begin
                bad++;
                $display("FAIL %s rdy_on_empty: got %0d rdy cycles want 0", nm, rdy_cnt - r0);
            end
        end

        exp_err = LenChk && (plen != int'(len));
        total++;
        if (err_o !== exp_err) begin
            bad++;
            $display("FAIL %s err_o: got %b want %b", nm, err_o, exp_err);
        end
    endtask

    task automatic check_all_zero(input string nm);
        logic [75:0] v;
        v = {val_o, lst_o, done_o, crc_start_o, crc_val_o, crc_lst_o, err_o, rdy_o,
             dat_o, num_o, crc_dat_o, crc_num_o};
        total++;
        if (v !== 76'd0) begin
            bad++;
            $display("FAIL %s outputs_after_reset: got %h want 0", nm, v);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        #1 rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_iend();
        run_chunk("iend", 32'd0, 0, 32'h49454E44, 1'b0, 1'b0);
        total++;
        if (mon_q.size() < 3 || mon_q[2].dat !== 32'hAE426082) begin
            bad++;
            $display("FAIL iend_crc_const: got %h want ae426082",
                     mon_q.size() >= 3 ? mon_q[2].dat : 32'hx);
        end
    endtask

    task automatic test_pacing();
        run_chunk("pacing", 32'd12, 12, $urandom, 1'b1, 1'b0);
    endtask

    task automatic test_partial();
        fixed_pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
        run_chunk("partial", 32'd5, 5, $urandom, 1'b0, 1'b0);
        fixed_pay.delete();
    endtask

    task automatic test_random();
        int l;
        for (int i = 0; i < 8; i++) begin
            l = $urandom_range(0, 20);
            run_chunk("random", 32'(l), l, $urandom, 1'($urandom), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        run_chunk("b2b_a", 32'd3, 3, $urandom, 1'b1, 1'b0);
        run_chunk("b2b_b", 32'd0, 0, $urandom, 1'b1, 1'b0);
        run_chunk("b2b_c", 32'd9, 9, $urandom, 1'b1, 1'b0);
    endtask

    task automatic test_mid_reset();
        int r0;
        @(posedge clk); #1;
        start_i = 1'b1; len_i = 32'd12; type_i = $urandom;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        val_i = 1'b1; dat_i = $urandom; num_i = 2'd3; lst_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        val_i = 1'b0;
        rstn = 1'b0;
        @(posedge clk); #1;
        mon_q.delete();
        cv_cyc.delete();
        r0 = rdy_cnt;
        @(negedge clk);
        check_all_zero("mid_reset");
        #1 rstn = 1'b1;
        repeat (12) @(negedge clk);
        total++;
        if (mon_q.size() != 0 || cv_cyc.size() != 0 || rdy_cnt != r0) begin
            bad++;
            $display("FAIL mid_reset_quiet: got %0d words %0d crc_val %0d rdy want 0 0 0",
                     mon_q.size(), cv_cyc.size(), rdy_cnt - r0);
        end
        run_chunk("iend_after_reset", 32'd0, 0, 32'h49454E44, 1'b0, 1'b0);
        total++;
        if (mon_q.size() < 3 || mon_q[2].dat !== 32'hAE426082) begin
            bad++;
            $display("FAIL iend_after_reset_crc: got %h want ae426082",
                     mon_q.size() >= 3 ? mon_q[2].dat : 32'hx);
        end
    endtask

    task automatic test_len_check();
        run_chunk("len_short", 32'd8, 4, $urandom, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        total++;
        if (err_o !== LenChk) begin
            bad++;
            $display("FAIL len_sticky: got %b want %b", err_o, LenChk);
        end
        run_chunk("len_long", 32'd4, 6, $urandom, 1'b0, 1'b0);
        run_chunk("len_ok", 32'd6, 6, $urandom, 1'b0, 1'b0);
    endtask

    task automatic test_ignore();
        run_chunk("ignore", 32'd8, 8, $urandom, 1'b0, 1'b1);
    endtask

    initial begin
        rstn = 1'b0;
        start_i = 1'b0;
        len_i = 32'd0;
        type_i = 32'd0;
        val_i = 1'b0;
        dat_i = 32'd0;
        num_i = 2'd0;
        lst_i = 1'b0;
        test_reset();
        test_iend();
        test_pacing();
        test_partial();
        test_random();
        test_back_to_back();
        test_mid_reset();
        test_len_check();
        test_ignore();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
